// File: rtl/rect_fill_engine.sv
// rect_fill_engine
//   Pixel-write generator for a 1280x1024 monochrome frame buffer. Accepts one
//   rectangle command (two corners plus a colour bit), sorts and clips it to the
//   visible area, then emits one buffer write per accepted cycle in row-major
//   order (x fastest).
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               command strobe, only honoured in IDLE
//   x0_i,y0_i,x1_i,y1_i   rectangle corners (any order)
//   color_i               fill colour
//   ready_i               downstream accepts the write when we_o=1 and ready_i=1
//   busy_o                command in progress (SETUP and FILL)
//   done_o                one-cycle completion pulse
//   we_o                  write valid
//   addr_x_o, addr_y_o    write address
//   color_o               write colour
module rect_fill_engine #(
    parameter int HD         = 1280,
    parameter int VD         = 1024,
    parameter int COORD_BITS = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [COORD_BITS-1:0] x0_i,
    input  logic [COORD_BITS-1:0] y0_i,
    input  logic [COORD_BITS-1:0] x1_i,
    input  logic [COORD_BITS-1:0] y1_i,
    input  logic                  color_i,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  we_o,
    output logic [COORD_BITS-1:0] addr_x_o,
    output logic [COORD_BITS-1:0] addr_y_o,
    output logic                  color_o
);

    localparam logic [COORD_BITS-1:0] HD_C  = COORD_BITS'(HD);
    localparam logic [COORD_BITS-1:0] VD_C  = COORD_BITS'(VD);
    localparam logic [COORD_BITS-1:0] HD_M1 = COORD_BITS'(HD - 1);
    localparam logic [COORD_BITS-1:0] VD_M1 = COORD_BITS'(VD - 1);
    localparam logic [COORD_BITS-1:0] ONE   = COORD_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched command
    logic [COORD_BITS-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic                  color_q, color_d;
    // Sorted and clipped bounds used during FILL
    logic [COORD_BITS-1:0] xl_q, xl_d, xr_q, xr_d, yb_q, yb_d;
    // Scan counters
    logic [COORD_BITS-1:0] x_q, x_d, y_q, y_d;

    // Corner sorting and clipping, evaluated from the latched command in SETUP
    logic [COORD_BITS-1:0] xl_s, xr_raw, xr_s, yt_s, yb_raw, yb_s;
    logic                  off_s;

    always_comb begin
        xl_s   = (x0_q < x1_q) ? x0_q : x1_q;
        xr_raw = (x0_q < x1_q) ? x1_q : x0_q;
        yt_s   = (y0_q < y1_q) ? y0_q : y1_q;
        yb_raw = (y0_q < y1_q) ? y1_q : y0_q;
        xr_s   = (xr_raw > HD_M1) ? HD_M1 : xr_raw;
        yb_s   = (yb_raw > VD_M1) ? VD_M1 : yb_raw;
        // Once xl is on-screen the clipped xr can never fall below it, so only
        // the near corner decides whether anything is visible.
        off_s  = (xl_s >= HD_C) || (yt_s >= VD_C);
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        color_d = color_q;
        xl_d    = xl_q;
        xr_d    = xr_q;
        yb_d    = yb_q;
        x_d     = x_q;
        y_d     = y_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    x0_d    = x0_i;
                    y0_d    = y0_i;
                    x1_d    = x1_i;
                    y1_d    = y1_i;
                    color_d = color_i;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (off_s) begin
                    state_d = S_DONE;
                end else begin
                    xl_d    = xl_s;
                    xr_d    = xr_s;
                    yb_d    = yb_s;
                    x_d     = xl_s;
                    y_d     = yt_s;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (ready_i) begin
                    // The last pixel leaves the counters parked on (xr, yb)
                    // so they never step past the clipped bounds.
                    if ((x_q == xr_q) && (y_q == yb_q)) begin
                        state_d = S_DONE;
                    end else if (x_q < xr_q) begin
                        x_d = x_q + ONE;
                    end else begin
                        x_d = xl_q;
                        y_d = y_q + ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= 1'b0;
            xl_q    <= '0;
            xr_q    <= '0;
            yb_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            xl_q    <= xl_d;
            xr_q    <= xr_d;
            yb_q    <= yb_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign we_o     = (state_q == S_FILL);
    assign busy_o   = (state_q == S_SETUP) || (state_q == S_FILL);
    assign done_o   = (state_q == S_DONE);
    assign addr_x_o = x_q;
    assign addr_y_o = y_q;
    assign color_o  = color_q;

endmodule
